div_operand_fifo: RTL and testbench

//  Operand queue directly upstream of the restoring divider. Accepts {dividend, divisor} pairs
//  on a valid/ready handshake and buffers up to DEPTH pairs. Presents them in order to the

---
 rtl/div_operand_fifo.sv | 92 +++++++++
 tb/tb_div_operand_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/div_operand_fifo.sv
// Operand queue feeding the restoring divider: buffers {dividend, divisor} pairs in order,
// dropping zero-divisor pairs and flagging each drop with a one-cycle dz_err pulse.
module div_operand_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_dividend,
  input  logic [WIDTH-1:0]         in_divisor,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_dividend,
  output logic [WIDTH-1:0]         out_divisor,
  output logic                     dz_err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] dvd_mem_q [DEPTH];
  logic [WIDTH-1:0] dvs_mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          dz_err_q, dz_err_d;

  logic accept, store, pop;

  always_comb begin
    in_ready  = (level_q != FULL_LVL);
    out_valid = (level_q != '0);
    accept    = in_valid & in_ready;
    store     = accept & (in_divisor != '0);
    pop       = out_valid & out_ready;
  end

  // Flush discards everything happening this cycle, including a zero-divisor error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    dz_err_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      dz_err_d = accept & (in_divisor == '0);
      if (store) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      if (store & ~pop)      level_d = level_q + LW'(1);
      else if (pop & ~store) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dz_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dz_err_q <= dz_err_d;
    end
  end

  // Storage holds data only; its contents are meaningless until level says otherwise.
  always_ff @(posedge clk) begin
    if (store && !flush) begin
      dvd_mem_q[wr_ptr_q] <= in_dividend;
      dvs_mem_q[wr_ptr_q] <= in_divisor;
    end
  end

  always_comb begin
    out_dividend = out_valid ? dvd_mem_q[rd_ptr_q] : '0;
    out_divisor  = out_valid ? dvs_mem_q[rd_ptr_q] : '0;
    dz_err       = dz_err_q;
    level        = level_q;
  end

endmodule

// File: tb/tb_div_operand_fifo.sv
// Directed bench for div_operand_fifo: handshake, ordering, zero-divisor screening,
// flush and async reset, plus a stalled stream checked against a queue model.
module tb_div_operand_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, out_ready;
  logic             in_ready, out_valid, dz_err;
  logic [WIDTH-1:0] in_dividend, in_divisor, out_dividend, out_divisor;
  logic [LW-1:0]    level;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] qd[$];
  logic [WIDTH-1:0] qv[$];
  int   sent, got, cyc;
  logic push_m, pop_m, zdv_m;

  always #5 clk = ~clk;

  div_operand_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dividend(out_dividend), .out_divisor(out_divisor),
    .dz_err(dz_err), .level(level)
  );

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input int dd, input int dv);
    in_valid    = v;
    in_dividend = WIDTH'(dd);
    in_divisor  = WIDTH'(dv);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    offer(1'b0, 0, 0);
    #12;
    chk("rst_level", level, 0);
    chk("rst_outvalid", out_valid, 0);
    chk("rst_inready", in_ready, 1);
    chk("rst_dz", dz_err, 0);
    chk("rst_outdvd", out_dividend, 0);
    chk("rst_outdvs", out_divisor, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // 1: single push, no bypass, then pop
    offer(1'b1, 100, 7);
    #1;
    chk("t1_nobypass", out_valid, 0);
    step();
    offer(1'b0, 0, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_dvd", out_dividend, 100);
    chk("t1_dvs", out_divisor, 7);
    chk("t1_level", level, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t1_level0", level, 0);
    chk("t1_valid0", out_valid, 0);
    chk("t1_dvd0", out_dividend, 0);
    chk("t1_dvs0", out_divisor, 0);

    // 2: fill to full, refuse a fifth, drain in order
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 10 * (i + 1), i + 1);
      step();
    end
    chk("t2_full_level", level, 4);
    chk("t2_full_inready", in_ready, 0);
    offer(1'b1, 50, 5);
    step();
    offer(1'b0, 0, 0);
    chk("t2_fifth_level", level, 4);
    chk("t2_head_stable", out_dividend, 10);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_dvd", out_dividend, 10 * (i + 1));
      chk("t2_drain_dvs", out_divisor, i + 1);
      step();
      if (i == 0) chk("t2_inready_rise", in_ready, 1);
    end
    out_ready = 1'b0;
    chk("t2_empty", level, 0);

    // 3: zero divisor dropped, single and back-to-back pulses
    offer(1'b1, 55, 0);
    step();
    offer(1'b0, 0, 0);
    chk("t3_dz", dz_err, 1);
    chk("t3_valid", out_valid, 0);
    chk("t3_level", level, 0);
    step();
    chk("t3_dz_pulse", dz_err, 0);
    offer(1'b1, 56, 0);
    step();
    chk("t3_b2b_dz1", dz_err, 1);
    step();
    offer(1'b0, 0, 0);
    chk("t3_b2b_dz2", dz_err, 1);
    step();
    chk("t3_b2b_end", dz_err, 0);

    // 4: simultaneous push and pop at level 2
    offer(1'b1, 1, 1); step();
    offer(1'b1, 2, 2); step();
    chk("t4_level2", level, 2);
    offer(1'b1, 9, 3);
    out_ready = 1'b1;
    step();
    offer(1'b0, 0, 0);
    chk("t4_level_hold", level, 2);
    chk("t4_head_dvd", out_dividend, 2);
    step();
    chk("t4_next_dvd", out_dividend, 9);
    chk("t4_next_dvs", out_divisor, 3);
    step();
    chk("t4_empty", level, 0);
    out_ready = 1'b0;

    // 5: stalled stream through pointer wrap, zero-divisor pairs removed
    sent = 0; got = 0; cyc = 0;
    while ((sent < 20 || qd.size() != 0) && cyc < 300) begin
      in_valid    = (sent < 20);
      in_dividend = WIDTH'(1000 + sent);
      in_divisor  = (sent % 5 == 3) ? '0 : WIDTH'(sent + 1);
      out_ready   = 1'($urandom_range(0, 1));
      #1;
      chk("s_inready", in_ready, qd.size() != DEPTH);
      chk("s_level", level, qd.size());
      chk("s_outvalid", out_valid, qd.size() != 0);
      if (qd.size() != 0) begin
        chk("s_dvd", out_dividend, qd[0]);
        chk("s_dvs", out_divisor, qv[0]);
      end
      pop_m  = out_ready && (qd.size() != 0);
      push_m = in_valid && (qd.size() != DEPTH);
      zdv_m  = (in_divisor == '0);
      @(posedge clk); #1;
      chk("s_dz", dz_err, push_m && zdv_m);
      if (pop_m) begin
        void'(qd.pop_front());
        void'(qv.pop_front());
        got++;
      end
      if (push_m) begin
        if (!zdv_m) begin
          qd.push_back(in_dividend);
          qv.push_back(in_divisor);
        end
        sent++;
      end
      cyc++;
    end
    offer(1'b0, 0, 0);
    out_ready = 1'b0;
    chk("s_sent", sent, 20);
    chk("s_got", got, 16);
    chk("s_final_level", level, 0);

    // 6: flush with a concurrent push, then async reset mid-stream
    offer(1'b1, 3, 1); step();
    offer(1'b1, 4, 1); step();
    offer(1'b1, 5, 1); step();
    chk("t6_level3", level, 3);
    offer(1'b1, 8, 2);
    flush = 1'b1;
    step();
    chk("t6_flush_level", level, 0);
    chk("t6_flush_valid", out_valid, 0);
    chk("t6_flush_inready", in_ready, 1);
    offer(1'b1, 7, 0);
    step();
    flush = 1'b0;
    offer(1'b0, 0, 0);
    chk("t6_flush_nodz", dz_err, 0);
    offer(1'b1, 11, 1); step();
    offer(1'b1, 0, 0);  step();
    offer(1'b1, 12, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_dz", dz_err, 0);
    chk("t6_rst_inready", in_ready, 1);
    chk("t6_rst_dvd", out_dividend, 0);
    chk("t6_rst_dvs", out_divisor, 0);
    offer(1'b0, 0, 0);
    step();
    reset = 1'b1;
    step();
    chk("t6_post_rst_level", level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
